// File: rtl/tx_pkt_fifo.sv
// tx_pkt_fifo: single-clock USB transmit FIFO with bus register map.
// Optional sticky ovf/unf error flags: define TX_FIFO_ERR_FLAGS_EN.
module tx_pkt_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6,
   parameter int FIFO_DEPTH = 64,
   parameter int PKT_MODE   = 0,
   parameter int AE_DEFAULT = 4
) (
   input  logic                  busClk,
   input  logic                  rstN,
   input  logic [2:0]            busAddress,
   input  logic                  busWriteEn,
   input  logic                  busStrobe_i,
   input  logic                  busFifoSelect,
   input  logic [DATA_WIDTH-1:0] busDataIn,
   output logic [DATA_WIDTH-1:0] busDataOut,
   input  logic                  fifoREn,
   output logic [DATA_WIDTH-1:0] fifoDataOut,
   output logic                  fifoEmpty,
   output logic                  fifoFull,
   output logic                  fifoAlmostEmpty
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] DEPTH = PW'(FIFO_DEPTH);
   localparam logic [PW-1:0] AE_RST = PW'(AE_DEFAULT);
   localparam logic PKT = (PKT_MODE != 0);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] commitPtr;
   logic [PW-1:0] aeThresh;
   logic [PW-1:0] used;
   logic [PW-1:0] avail;
   logic [15:0]   usedExt;

   logic acc;
   logic wrAcc;
   logic rdAcc;
   logic ctrlWr;
   logic pushReq;
   logic push;
   logic pop;
   logic forceEmpty;
   logic abort;
   logic pending;
   logic ovf;
   logic unf;

   logic [DATA_WIDTH-1:0] rdData;

   assign acc   = busStrobe_i & busFifoSelect;
   assign wrAcc = acc & busWriteEn;
   assign rdAcc = acc & ~busWriteEn;

   assign pushReq    = wrAcc & (busAddress == 3'd0);
   assign ctrlWr     = wrAcc & (busAddress == 3'd2);
   assign forceEmpty = ctrlWr & busDataIn[0];
   assign abort      = ctrlWr & busDataIn[2] & PKT;

   assign used    = wrPtr - rdPtr;
   assign avail   = commitPtr - rdPtr;
   assign usedExt = 16'(used);
   assign pending = (wrPtr != commitPtr);

   assign fifoFull        = (used == DEPTH);
   assign fifoEmpty       = (avail == '0);
   assign fifoAlmostEmpty = (avail <= aeThresh);

   assign push = pushReq & ~fifoFull;
   assign pop  = fifoREn & ~fifoEmpty;

   assign fifoDataOut = mem[rdPtr[ADDR_WIDTH-1:0]];

   generate
      if (PKT_MODE != 0) begin : gPkt
         logic [PW-1:0] commitReg;
         logic          commit;

         assign commit = ctrlWr & busDataIn[1];

         // Commit publishes all pending words; abort outranks it.
         always_ff @(posedge busClk or negedge rstN) begin
            if (!rstN)
               commitReg <= '0;
            else if (forceEmpty)
               commitReg <= '0;
            else if (commit & ~abort)
               commitReg <= wrPtr;
         end

         assign commitPtr = commitReg;
      end else begin : gStream
         assign commitPtr = wrPtr;
      end
   endgenerate

   // Storage write port; contents are intentionally not reset.
   always_ff @(posedge busClk) begin
      if (push & ~forceEmpty)
         mem[wrPtr[ADDR_WIDTH-1:0]] <= busDataIn;
   end

   // Write and read pointers; forceEmpty overrides every other update.
   always_ff @(posedge busClk or negedge rstN) begin
      if (!rstN) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else if (forceEmpty) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (abort)
            wrPtr <= commitPtr;
         else if (push)
            wrPtr <= wrPtr + PW'(1);
         if (pop)
            rdPtr <= rdPtr + PW'(1);
      end
   end

   // Almost-empty threshold register.
   always_ff @(posedge busClk or negedge rstN) begin
      if (!rstN)
         aeThresh <= AE_RST;
      else if (wrAcc & (busAddress == 3'd5))
         aeThresh <= PW'(busDataIn);
   end

`ifdef TX_FIFO_ERR_FLAGS_EN
   logic clrErr;
   logic ovfSet;
   logic unfSet;

   assign clrErr = ctrlWr & busDataIn[3];
   assign ovfSet = pushReq & fifoFull;
   assign unfSet = fifoREn & fifoEmpty;

   // Sticky error flags; a new event beats a same-cycle clear.
   always_ff @(posedge busClk or negedge rstN) begin
      if (!rstN) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         ovf <= ovfSet | (ovf & ~clrErr);
         unf <= unfSet | (unf & ~clrErr);
      end
   end
`else
   assign ovf = 1'b0;
   assign unf = 1'b0;
`endif

   // Register read decode.
   always_comb begin
      rdData = '0;
      unique case (busAddress)
         3'd1: rdData[5:0] = {pending, fifoAlmostEmpty, unf,
                              ovf, fifoFull, fifoEmpty};
         3'd3: rdData[7:0] = usedExt[7:0];
         3'd4: rdData[7:0] = usedExt[15:8];
         3'd5: rdData = DATA_WIDTH'(aeThresh);
         default: rdData = '0;
      endcase
   end

   // Registered bus read data, held between read accesses.
   always_ff @(posedge busClk or negedge rstN) begin
      if (!rstN)
         busDataOut <= '0;
      else if (rdAcc)
         busDataOut <= rdData;
   end

endmodule

// File: doc/tx_pkt_fifo.md
Name: tx_pkt_fifo

Overview:
Single-clock, parametrised USB transmit FIFO with an integrated bus register interface and an optional packet-commit mode.
- Bus side pushes bytes and controls or inspects the FIFO through a 3-bit register map.
- USB transmit side pops with a show-ahead read port.
- In packet mode, written data stays invisible to the reader until software commits it, and it can be aborted.
- Replaces the dual-clock FIFO plus separate bus-interface pair wherever bus and USB logic share one clock.

Parameters:
DATA_WIDTH, 8, FIFO word and bus data width; must be >= 8.
ADDR_WIDTH, 6, log2 of depth; range 2..15.
FIFO_DEPTH, 64, must equal 2**ADDR_WIDTH.
PKT_MODE, 0, 1 = writes held until commit; 0 = stream mode, writes visible immediately.
AE_DEFAULT, 4, reset value of the almost-empty threshold register.

Ports:
busClk  in  1  single clock for all logic.
rstN  in  1  asynchronous active-low reset.
busAddress  in  3  register select.
busWriteEn  in  1  1 = write access, 0 = read access.
busStrobe_i  in  1  access qualifier, one access per cycle.
busFifoSelect  in  1  block select.
busDataIn  in  DATA_WIDTH  bus write data.
busDataOut  out  DATA_WIDTH  registered bus read data.
fifoREn  in  1  pop request from the USB transmitter.
fifoDataOut  out  DATA_WIDTH  word at the head of the FIFO (show-ahead).
fifoEmpty  out  1  no committed data available.
fifoFull  out  1  storage full.
fifoAlmostEmpty  out  1  committed count <= threshold.

Behaviour:
- Clocking and reset: one clock, busClk. Reset is asynchronous, active-low (rstN).
- Pointers: wrPtr, commitPtr and rdPtr, each ADDR_WIDTH+1 bits, wrapping modulo 2*FIFO_DEPTH.
- Occupancy:
  - used = wrPtr-rdPtr.
  - avail = commitPtr-rdPtr.
  - When PKT_MODE=0, commitPtr is wrPtr (combinational alias).
- Flags:
  - fifoFull = (used==FIFO_DEPTH).
  - fifoEmpty = (avail==0).
  - fifoAlmostEmpty = (avail <= aeThresh).
  - All three are combinational from registered state.
- Access qualifier: acc = busStrobe_i & busFifoSelect.
- Register writes (acc & busWriteEn):
  - Addr 0: push busDataIn if !fifoFull, wrPtr++. If full, the push is dropped and sets ovf.
  - Addr 2: control register.
    - bit0 forceEmpty: wrPtr, commitPtr and rdPtr all go to 0.
    - bit1 commit: commitPtr <= wrPtr.
    - bit2 abort: wrPtr <= commitPtr.
    - bit3 clrErr: clears error flags.
    - Priority: forceEmpty > abort > commit. Bits 1 and 2 are ignored when PKT_MODE=0.
  - Addr 5: aeThresh <= busDataIn[ADDR_WIDTH:0].
  - Other addresses: ignored.
- Register reads (acc & !busWriteEn): busDataOut is loaded on the next edge (1-cycle latency). It holds its value while there is no read access.
  - Addr 1 status: {.., pending, almostEmpty, unf, ovf, full, empty} in bits 5..0.
    - pending = (wrPtr!=commitPtr).
  - Addr 3: used[7:0].
  - Addr 4: used[15:8], zero-extended.
  - Addr 5: aeThresh.
  - Others: 0.
  - Upper bits beyond those defined read 0.
- Pop: fifoREn & !fifoEmpty advances rdPtr. fifoDataOut = mem[rdPtr[ADDR_WIDTH-1:0]] with asynchronous read, valid while !fifoEmpty. Pop while empty is ignored and sets unf.
- Latency: a word pushed at edge N (stream mode) clears fifoEmpty after edge N. In packet mode, the commit edge makes data visible.
- Simultaneous push and pop: both happen and used is unchanged. A pop while full frees a slot after the edge, not the same cycle.
- forceEmpty in the same cycle as a pop: forceEmpty wins and the pop is discarded.
- Abort never touches committed data or rdPtr. Commit with nothing pending is a no-op.
- Reset values:
  - wrPtr, commitPtr, rdPtr = 0.
  - aeThresh = AE_DEFAULT.
  - ovf = unf = 0.
  - busDataOut = 0.
  - Hence fifoEmpty=1, fifoFull=0, fifoAlmostEmpty=1.
  - Memory contents are not reset.
  - Reset mid-operation discards all data, including pending data.

Optional Feature:
TX_FIFO_ERR_FLAGS_EN.
- Defined: sticky ovf (dropped push) and unf (pop while empty) flags in status bits 2/3. Each is set on its event and cleared by control bit3 or reset. A set in the same cycle as a clear wins.
- Undefined: no flag registers exist, status bits 2/3 read 0, and control bit3 is ignored.

Test Plan:
- Reset, then read status (addr1) -> busDataOut = 0x11 one cycle later (empty, almostEmpty), fifoFull=0.
- Stream mode: push 0xA5, 0x3C -> after the first edge fifoEmpty=0 and fifoDataOut=0xA5. Pop twice -> 0xA5 then 0x3C; fifoEmpty=1; count (addr3)=0.
- Fill all 64 entries, then push 0xFF -> fifoFull=1, entry dropped, status bit2=1 (macro on) or 0 (off). Pop 64 times -> data in order with wrap-around correct.
- PKT_MODE=1: push 3 bytes -> fifoEmpty stays 1, pending=1, count=3. Commit -> fifoEmpty=0, avail=3. Push 2 more, abort -> count=3, pending=0.
- aeThresh=2 with 3 committed -> fifoAlmostEmpty=0. One pop -> 1.
- With 10 entries, forceEmpty in the same cycle as fifoREn -> all pointers 0, fifoEmpty=1, count=0. Then pop while empty -> unf set; control bit3 -> cleared.
